watch_time_counter: RTL and testbench
=====================================

# watch_time_counter

Timekeeping core of the watch. Divides the system clock to a 1 Hz tick and maintains hours, minutes and seconds as 7-bit binary values (0–99 range). These values feed the tens/units digit splitters that drive the display. Supports run/stop and per-field loading from the set-mode logic.

## Interface

Parameters:
- CLK_HZ, 50_000_000: system clock cycles per second tick; must be ≥ 2.
- HOURS, 24: hour modulus; legal values are 12 or 24.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset; synchronous, active-high.
- run  in  1  1 = timekeeping advances; 0 = prescaler and time hold.
- set_en  in  1  one-cycle load strobe.
- set_sel  in  2  field to load: 0 = sec, 1 = min, 2 = hour, 3 = reserved.
- set_val  in  7  value to load.
- sec  out  7  seconds, 0..59.
- min  out  7  minutes, 0..59.
- hour  out  7  hours, 0..HOURS-1.
- sec_tick  out  1  one-cycle pulse when seconds advance.
- day_wrap  out  1  one-cycle pulse when time wraps from HOURS-1:59:59 to 0:00:00.
- set_err  out  1  one-cycle pulse when a load is rejected.

## Operation

- Prescaler:
  - Counts 0..CLK_HZ-1 while run=1. Holds its value while run=0.
  - Width is $clog2(CLK_HZ).
  - A tick is generated on the cycle the prescaler reaches CLK_HZ-1 with run=1; on that cycle the prescaler returns to 0.
- On a tick:
  - sec increments.
  - sec 59→0 carries into min; min 59→0 carries into hour.
  - hour HOURS-1→0 asserts day_wrap.
  - All carries resolve in the same cycle.
- Load (set_en=1):
  - Legal when the selected field is sec or min with set_val ≤ 59, or hour with set_val ≤ HOURS-1. The selected field takes set_val; the other fields are unchanged.
  - Illegal when set_val is out of range or set_sel=3. No field changes and set_err pulses.
  - Every set_en, legal or not, clears the prescaler to 0 and suppresses any tick in that cycle. sec_tick and day_wrap stay 0 that cycle.
  - Load works regardless of run.
- Priority, highest first: rst, set_en, tick.
- All outputs are registered. No combinational path from inputs to outputs.
- Arithmetic: fields are compared against limits at full 7 bits. Values above the limit never occur internally.

## Timing

- Reset values: sec=0, min=0, hour=0, sec_tick=0, day_wrap=0, set_err=0, prescaler=0.
- Reset mid-count discards prescaler progress. The first tick after rst deasserts arrives CLK_HZ cycles of run=1 later.
- Tick latency:
  - The field update is visible on the clock edge that ends the CLK_HZ-th run cycle.
  - sec_tick is high in the same cycle the new sec value is first visible.
  - day_wrap is high in the cycle 0:00:00 is first visible.
- Load latency: one cycle. The value is visible, or set_err is high, in the cycle after set_en is sampled.
- run deassertion freezes the prescaler mid-count. Reassertion resumes from the held count with no loss.
- Back-to-back set_en is allowed on consecutive cycles. Each load is evaluated independently, and the prescaler stays 0 throughout.
- With set_en held continuously, no tick ever occurs.

## Structure

- Shared package watch_pkg:
  - Field-select encoding constants: SEL_SEC=0, SEL_MIN=1, SEL_HOUR=2.
  - Limit constants: SEC_MAX=59, MIN_MAX=59.
  - The 7-bit time-value width constant, shared with the digit splitter.
- Sub-module tick_divider holds the prescaler.
  - Parameter: CLK_HZ.
  - Ports: clk, rst, en (= run), clr (= set_en), tick.
  - tick is combinational from the prescaler state, asserted when count = CLK_HZ-1 and en=1 and clr=0.
- The top level holds the three field registers, carry logic, load validation and the pulse registers.

## Test plan

All scenarios use CLK_HZ=4, HOURS=24.

- Reset then run=1 for 8 cycles → sec_tick pulses twice, 4 cycles apart; sec=2; min=0, hour=0.
- Load hour=23, min=59, sec=59, then run for 4 cycles → time becomes 0:0:0 in the same cycle day_wrap=1 and sec_tick=1.
- Load sec=60; load hour=24; load with set_sel=3 → set_err pulses once per attempt; fields unchanged.
- run=1 for 2 cycles, run=0 for 10 cycles, run=1 for 2 cycles → exactly one tick, with no tick during the hold.
- Assert set_en (sec=30) on the cycle the prescaler equals 3 → sec=30 with no sec_tick; the next tick arrives 4 run cycles later and gives sec=31.
- Set time to 12:34:56 and assert rst mid-prescale → all outputs 0 the next cycle; the first tick arrives 4 cycles after rst deasserts.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the watch timekeeping path: time-value width,
// field-select encoding, field limits and a load-range helper.
package watch_pkg;

  // Width of every time field. The digit splitter uses the same width.
  localparam int TIME_W = 7;

  typedef logic [TIME_W-1:0] time_val_t;
  typedef logic [1:0]        field_sel_t;

  // Field-select encoding used by the set-mode logic. Code 3 is reserved.
  localparam field_sel_t SEL_SEC  = 2'd0;
  localparam field_sel_t SEL_MIN  = 2'd1;
  localparam field_sel_t SEL_HOUR = 2'd2;

  // Highest legal value of the seconds and minutes fields.
  localparam time_val_t SEC_MAX = 7'd59;
  localparam time_val_t MIN_MAX = 7'd59;

  // True when a load of 'val' into field 'sel' keeps that field in range.
  // The comparison uses all 7 bits, so values up to 127 are rejected
  // correctly. The reserved select code is always illegal.
  function automatic logic load_is_legal(input field_sel_t sel,
                                         input time_val_t  val,
                                         input time_val_t  hour_max);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEL_SEC:  ok = (val <= SEC_MAX);
      SEL_MIN:  ok = (val <= MIN_MAX);
      SEL_HOUR: ok = (val <= hour_max);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage : watch_pkg

// File: rtl/tick_divider.sv
// Prescaler that divides the system clock down to a one-per-second tick.
// The count advances only while 'en' is high and is forced to zero by
// 'clr'. The tick is decoded combinationally from the count so the parent
// can register the field update on the same edge that wraps the count.
module tick_divider #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // At least one bit even for the smallest legal divider.
  localparam int W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] r_count;
  logic         w_at_last;

  assign w_at_last = (r_count == LAST);

  // Tick fires on the last count of the period while enabled, unless a
  // load is clearing the prescaler in the same cycle.
  assign tick = en && !clr && w_at_last;

  // Count 0..CLK_HZ-1 while enabled; hold while disabled; clear on rst/clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + W'(1);
      end
    end
  end

endmodule : tick_divider

// File: rtl/watch_time_counter.sv
// Timekeeping core: hours/minutes/seconds registers with cascaded carry,
// validated per-field loading and registered status pulses. All outputs
// come straight from flops; priority is reset, then load, then tick.
module watch_time_counter
  import watch_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int HOURS  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_en,
  input  logic [1:0]        set_sel,
  input  logic [TIME_W-1:0] set_val,
  output logic [TIME_W-1:0] sec,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] hour,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              set_err
);

  localparam time_val_t HOUR_MAX = TIME_W'(HOURS - 1);

  // Field and pulse registers.
  time_val_t r_sec;
  time_val_t r_min;
  time_val_t r_hour;
  logic      r_sec_tick;
  logic      r_day_wrap;
  logic      r_set_err;

  // Next-state values and decoded conditions.
  logic      w_tick;
  logic      w_load_ok;
  time_val_t w_sec_nxt;
  time_val_t w_min_nxt;
  time_val_t w_hour_nxt;
  logic      w_sec_tick_nxt;
  logic      w_day_wrap_nxt;
  logic      w_set_err_nxt;

  // A load always clears the prescaler, so a load cycle never ticks.
  tick_divider #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (set_en),
    .tick (w_tick)
  );

  assign w_load_ok = load_is_legal(set_sel, set_val, HOUR_MAX);

  // Next field values: a load replaces one field, a tick ripples the carry
  // through seconds, minutes and hours within a single cycle.
  always_comb begin
    w_sec_nxt      = r_sec;
    w_min_nxt      = r_min;
    w_hour_nxt     = r_hour;
    w_sec_tick_nxt = 1'b0;
    w_day_wrap_nxt = 1'b0;
    w_set_err_nxt  = 1'b0;
    if (set_en) begin
      if (w_load_ok) begin
        case (set_sel)
          SEL_SEC:  w_sec_nxt  = set_val;
          SEL_MIN:  w_min_nxt  = set_val;
          SEL_HOUR: w_hour_nxt = set_val;
          default:  w_sec_nxt  = r_sec;
        endcase
      end else begin
        w_set_err_nxt = 1'b1;
      end
    end else if (w_tick) begin
      w_sec_tick_nxt = 1'b1;
      if (r_sec == SEC_MAX) begin
        w_sec_nxt = '0;
        if (r_min == MIN_MAX) begin
          w_min_nxt = '0;
          if (r_hour == HOUR_MAX) begin
            w_hour_nxt     = '0;
            w_day_wrap_nxt = 1'b1;
          end else begin
            w_hour_nxt = r_hour + TIME_W'(1);
          end
        end else begin
          w_min_nxt = r_min + TIME_W'(1);
        end
      end else begin
        w_sec_nxt = r_sec + TIME_W'(1);
      end
    end
  end

  // Register fields and one-cycle pulses; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_sec      <= w_sec_nxt;
      r_min      <= w_min_nxt;
      r_hour     <= w_hour_nxt;
      r_sec_tick <= w_sec_tick_nxt;
      r_day_wrap <= w_day_wrap_nxt;
      r_set_err  <= w_set_err_nxt;
    end
  end

  assign sec      = r_sec;
  assign min      = r_min;
  assign hour     = r_hour;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign set_err  = r_set_err;

endmodule : watch_time_counter

// File: tb/tb_watch_time_counter.sv
// Self-checking bench for watch_time_counter (CLK_HZ=4, HOURS=24).
// The reference model keeps the time of day as a single seconds-since-
// midnight integer plus a count of run cycles since the last clear.
module tb_watch_time_counter;

  localparam int CLK_HZ = 4;
  localparam int HOURS  = 24;
  localparam int DAY_S  = HOURS * 3600;

  // Clock and reset block.
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic [6:0] set_val = 7'd0;
  logic [6:0] sec, min, hour;
  logic       sec_tick, day_wrap, set_err;

  always #5 clk = ~clk;

  watch_time_counter #(
    .CLK_HZ (CLK_HZ),
    .HOURS  (HOURS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_en   (set_en),
    .set_sel  (set_sel),
    .set_val  (set_val),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap),
    .set_err  (set_err)
  );

  // Reference model state.
  int m_t;
  int m_run_cnt;
  bit m_tick, m_wrap, m_err;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Model one clock edge from the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit rn, input bit se,
                            input int sel, input int val);
    int h, m, s;
    m_tick = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      m_t = 0; m_run_cnt = 0;
    end else if (se) begin
      m_run_cnt = 0;
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      if (sel == 0 && val < 60)         s = val;
      else if (sel == 1 && val < 60)    m = val;
      else if (sel == 2 && val < HOURS) h = val;
      else m_err = 1;
      m_t = h * 3600 + m * 60 + s;
    end else if (rn) begin
      m_run_cnt++;
      if (m_run_cnt == CLK_HZ) begin
        m_run_cnt = 0;
        m_t = (m_t + 1) % DAY_S;
        m_tick = 1;
        m_wrap = (m_t == 0);
      end
    end
  endtask

  // Driver: apply inputs, clock once, update model, compare all outputs.
  task automatic step(input bit r, input bit rn, input bit se,
                      input int sel, input int val);
    rst = r; run = rn; set_en = se;
    set_sel = 2'(sel); set_val = 7'(val);
    @(posedge clk);
    model_edge(r, rn, se, sel, val);
    #1;
    chk("sec",      sec,      7'(m_t % 60));
    chk("min",      min,      7'((m_t / 60) % 60));
    chk("hour",     hour,     7'(m_t / 3600));
    chk("sec_tick", {6'd0, sec_tick}, {6'd0, m_tick});
    chk("day_wrap", {6'd0, day_wrap}, {6'd0, m_wrap});
    chk("set_err",  {6'd0, set_err},  {6'd0, m_err});
    if (sec_tick === 1'b1) tick_count++;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  initial begin
    m_t = 0; m_run_cnt = 0;

    // Reset state.
    step(1, 0, 0, 0, 0);
    chk("reset_sec", sec, 7'd0);
    chk("reset_flags", {4'd0, sec_tick, day_wrap, set_err}, 7'd0);

    // Run 8 cycles: two ticks four cycles apart.
    step(0, 0, 0, 0, 0);
    tick_count = 0;
    idle_run(3);
    chk("tp1_no_early_tick", 7'(tick_count), 7'd0);
    idle_run(1);
    chk("tp1_first_tick", {6'd0, sec_tick}, 7'd1);
    idle_run(4);
    chk("tp1_ticks", 7'(tick_count), 7'd2);
    chk("tp1_sec", sec, 7'd2);
    chk("tp1_min", min, 7'd0);

    // Day wrap from 23:59:59.
    step(0, 0, 1, 2, 23);
    step(0, 0, 1, 1, 59);
    step(0, 0, 1, 0, 59);
    idle_run(4);
    chk("tp2_hour", hour, 7'd0);
    chk("tp2_min", min, 7'd0);
    chk("tp2_sec", sec, 7'd0);
    chk("tp2_wrap", {6'd0, day_wrap}, 7'd1);
    chk("tp2_tick", {6'd0, sec_tick}, 7'd1);

    // Illegal loads.
    step(0, 0, 1, 0, 60);
    chk("tp3_sec60_err", {6'd0, set_err}, 7'd1);
    step(0, 0, 1, 2, 24);
    chk("tp3_hour24_err", {6'd0, set_err}, 7'd1);
    step(0, 0, 1, 3, 5);
    chk("tp3_sel3_err", {6'd0, set_err}, 7'd1);
    chk("tp3_sec_kept", sec, 7'd0);
    step(0, 0, 0, 0, 0);
    chk("tp3_err_pulse", {6'd0, set_err}, 7'd0);

    // Run hold: 2 run, 10 held, 2 run -> exactly one tick.
    step(1, 0, 0, 0, 0);
    tick_count = 0;
    idle_run(2);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    chk("tp4_hold_no_tick", 7'(tick_count), 7'd0);
    idle_run(2);
    chk("tp4_one_tick", 7'(tick_count), 7'd1);

    // Load on the would-be tick cycle suppresses it.
    step(1, 0, 0, 0, 0);
    idle_run(3);
    step(0, 1, 1, 0, 30);
    chk("tp5_sec30", sec, 7'd30);
    chk("tp5_no_tick", {6'd0, sec_tick}, 7'd0);
    tick_count = 0;
    idle_run(3);
    chk("tp5_wait", 7'(tick_count), 7'd0);
    idle_run(1);
    chk("tp5_sec31", sec, 7'd31);

    // Reset mid-prescale from 12:34:56.
    step(0, 0, 1, 2, 12);
    step(0, 0, 1, 1, 34);
    step(0, 0, 1, 0, 56);
    idle_run(2);
    step(1, 1, 0, 0, 0);
    chk("tp6_hour", hour, 7'd0);
    chk("tp6_sec", sec, 7'd0);
    tick_count = 0;
    idle_run(3);
    chk("tp6_no_tick", 7'(tick_count), 7'd0);
    idle_run(1);
    chk("tp6_tick", {6'd0, sec_tick}, 7'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int sel, val;
      bit r, rn, se;
      r   = ($urandom_range(0, 99) == 0);
      rn  = ($urandom_range(0, 9) != 0);
      se  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 3);
      val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127)
                                        : $urandom_range(0, 59);
      if ($urandom_range(0, 19) == 0 && !r) begin
        // Jump close to a carry boundary to exercise the cascade.
        step(0, 0, 1, 0, 59);
        step(0, 0, 1, 1, 59);
        step(0, 0, 1, 2, 23);
      end
      step(r, rn, se, sel, val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_watch_time_counter
